// File: rtl/fir_pkg.sv
// Shared helpers for the parametrised FIR filter.
// Accumulator sizing and default binomial coefficients.
package fir_pkg;

    localparam int MAX_TAPS = 16;

    // Wide enough that TAPS full-scale products never overflow.
    function automatic int acc_width(input int width,
                                     input int coef_width,
                                     input int taps);
        return width + coef_width + $clog2(taps);
    endfunction

    // Binomial C(taps-1, idx), clipped to the coefficient range.
    function automatic int default_coef(input int taps,
                                        input int idx,
                                        input int coef_width);
        int c;
        int lim;
        c = 1;
        for (int i = 0; i < idx; i++) begin
            c = c * (taps - 1 - i) / (i + 1);
        end
        lim = (coef_width >= 31) ? 32'h7fff_ffff
                                 : (1 << coef_width) - 1;
        return (c > lim) ? lim : c;
    endfunction

endpackage

// File: rtl/fir_tap_line.sv
// Enable-gated sample delay line with sync reset.
// Ports: clk, rst, en (shift), din, taps (flat, tap 0 = newest).
module fir_tap_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [WIDTH-1:0]       din,
    output logic [DEPTH*WIDTH-1:0] taps
);

    logic [WIDTH-1:0] line_q [DEPTH];
    logic [WIDTH-1:0] line_d [DEPTH];

    always_comb begin
        line_d = line_q;
        if (en) begin
            line_d[0] = din;
            for (int k = 1; k < DEPTH; k++) begin
                line_d[k] = line_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                line_q[k] <= '0;
            end
        end else begin
            line_q <= line_d;
        end
    end

    always_comb begin
        taps = '0;
        for (int k = 0; k < DEPTH; k++) begin
            taps[k*WIDTH +: WIDTH] = line_q[k];
        end
    end

endmodule

// File: rtl/fir_filter_param.sv
// Streaming FIR: MAC + round (stage 1), shift + saturate (out).
// Ports: CLK, RST, in_valid/in_data, round_en, coef_we/idx/data, out_valid/out_data.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TAPS       = 3,
    parameter int COEF_WIDTH = 4,
    parameter int SHIFT      = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  round_en,
    input  logic                  coef_we,
    input  logic [3:0]            coef_idx,
    input  logic [COEF_WIDTH-1:0] coef_data,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data
);

    localparam int ACC_W = acc_width(WIDTH, COEF_WIDTH, TAPS);
    localparam int DEPTH = TAPS - 1;
    localparam int RSH   = (SHIFT > 0) ? SHIFT - 1 : 0;
    // Half an LSB of the shifted result; zero when nothing is shifted out.
    localparam logic [ACC_W-1:0] RND = ACC_W'(SHIFT > 0) << RSH;

    logic [DEPTH*WIDTH-1:0] taps;
    logic [WIDTH-1:0]       x [TAPS];

    logic [COEF_WIDTH-1:0]  coef_q [TAPS];
    logic [COEF_WIDTH-1:0]  coef_d [TAPS];

    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       shifted;
    logic [ACC_W-1:0]       s1_acc_q, s1_acc_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]       out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;

    fir_tap_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tap_line (
        .clk  (CLK),
        .rst  (RST),
        .en   (in_valid),
        .din  (in_data),
        .taps (taps)
    );

    always_comb begin
        x[0] = in_data;
        for (int k = 1; k < TAPS; k++) begin
            x[k] = taps[(k-1)*WIDTH +: WIDTH];
        end
    end

    // Uses the registered coefficients, so a same-edge write
    // only affects the following sample.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + ACC_W'(coef_q[k]) * ACC_W'(x[k]);
        end
        if (round_en) begin
            acc = acc + RND;
        end
    end

    always_comb begin
        coef_d = coef_q;
        for (int k = 0; k < TAPS; k++) begin
            if (coef_we && coef_idx == 4'(k)) begin
                coef_d[k] = coef_data;
            end
        end
    end

    always_comb begin
        s1_valid_d = in_valid;
        s1_acc_d   = in_valid ? acc : s1_acc_q;
    end

    always_comb begin
        shifted     = s1_acc_q >> SHIFT;
        out_valid_d = s1_valid_q;
        out_data_d  = out_data_q;
        if (s1_valid_q) begin
            if (|shifted[ACC_W-1:WIDTH]) begin
                out_data_d = '1;
            end else begin
                out_data_d = shifted[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= COEF_WIDTH'(default_coef(TAPS, k, COEF_WIDTH));
            end
            s1_acc_q    <= '0;
            s1_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            coef_q      <= coef_d;
            s1_acc_q    <= s1_acc_d;
            s1_valid_q  <= s1_valid_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param at default parameters.
// Expected outputs are hand-computed for c=[1,2,1], >>2.
module tb_fir_filter_param;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       round_en = 1'b0;
    logic       coef_we = 1'b0;
    logic [3:0] coef_idx = '0;
    logic [3:0] coef_data = '0;
    logic       out_valid;
    logic [7:0] out_data;

    int n_chk  = 0;
    int n_pass = 0;

    fir_filter_param #(
        .WIDTH      (8),
        .TAPS       (3),
        .COEF_WIDTH (4),
        .SHIFT      (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .round_en  (round_en),
        .coef_we   (coef_we),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        step();
        RST = 1'b0;
    endtask

    task automatic wr_coef(input int idx, input int val);
        coef_we   = 1'b1;
        coef_idx  = 4'(idx);
        coef_data = 4'(val);
        step();
        coef_we = 1'b0;
    endtask

    // Three back-to-back samples; results appear 2 edges after each accept.
    task automatic run3(input string tag,
                        input int a, input int b, input int c,
                        input int ea, input int eb, input int ec);
        in_valid = 1'b1;
        in_data  = 8'(a);
        step();
        chk({tag, "_v0"}, int'(out_valid), 0);
        in_data = 8'(b);
        step();
        chk({tag, "_v1"}, int'(out_valid), 1);
        chk({tag, "_y1"}, int'(out_data), ea);
        in_data = 8'(c);
        step();
        chk({tag, "_y2"}, int'(out_data), eb);
        in_valid = 1'b0;
        step();
        chk({tag, "_y3"}, int'(out_data), ec);
        step();
        chk({tag, "_vend"}, int'(out_valid), 0);
    endtask

    initial begin
        // Test 1: reset state and basic smoothing
        step();
        do_reset();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        run3("basic", 4, 8, 12, 1, 4, 8);
        chk("basic_hold", int'(out_data), 8);

        // Test 2: impulse with and without rounding
        do_reset();
        round_en = 1'b1;
        run3("imp_rnd", 1, 0, 0, 0, 1, 0);
        do_reset();
        round_en = 1'b0;
        run3("imp_trn", 1, 0, 0, 0, 0, 0);

        // Test 3: saturation, then decay with defaults restored
        do_reset();
        wr_coef(0, 15);
        wr_coef(1, 15);
        wr_coef(2, 15);
        run3("sat", 255, 255, 255, 255, 255, 255);
        wr_coef(0, 1);
        wr_coef(1, 2);
        wr_coef(2, 1);
        run3("decay", 0, 0, 0, 191, 63, 0);

        // Test 4: bubbles between samples
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'd4;
        step();
        in_valid = 1'b0;
        step();
        chk("bub_v1", int'(out_valid), 1);
        chk("bub_y1", int'(out_data), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bub_gap_v", int'(out_valid), 0);
            chk("bub_gap_hold", int'(out_data), 1);
        end
        in_valid = 1'b1;
        in_data  = 8'd8;
        step();
        in_valid = 1'b0;
        step();
        chk("bub_y2", int'(out_data), 4);
        step();
        chk("bub_gap2_v", int'(out_valid), 0);
        in_valid = 1'b1;
        in_data  = 8'd12;
        step();
        in_valid = 1'b0;
        step();
        chk("bub_v3", int'(out_valid), 1);
        chk("bub_y3", int'(out_data), 8);

        // Test 5: same-edge coefficient write uses old value
        do_reset();
        coef_we   = 1'b1;
        coef_idx  = 4'd0;
        coef_data = 4'd3;
        in_valid  = 1'b1;
        in_data   = 8'd4;
        step();
        coef_we = 1'b0;
        in_data = 8'd4;
        step();
        chk("same_old", int'(out_data), 1);
        in_valid = 1'b0;
        step();
        chk("same_new", int'(out_data), 5);
        wr_coef(7, 15);
        in_valid = 1'b1;
        in_data  = 8'd4;
        step();
        in_valid = 1'b0;
        step();
        chk("idx7_ignored", int'(out_data), 6);

        // Test 6: reset with samples in flight
        wr_coef(0, 15);
        in_valid = 1'b1;
        in_data  = 8'd100;
        step();
        step();
        in_valid = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("midrst_v", int'(out_valid), 0);
        chk("midrst_d", int'(out_data), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_nopulse", int'(out_valid), 0);
        end
        in_valid = 1'b1;
        in_data  = 8'd8;
        step();
        in_valid = 1'b0;
        step();
        chk("post_rst_v", int'(out_valid), 1);
        chk("post_rst_y", int'(out_data), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
